// File: rtl/ctr_drbg_seed_ctrl.sv
// CTR_DRBG (no derivation function) seed controller: owns Key/V/reseed_counter,
// runs Instantiate/Reseed through an external update engine, tracks the reseed interval.
module ctr_drbg_seed_ctrl #(
  parameter int KEY_W           = 256,
  parameter int BLK_W           = 128,
  parameter int SEED_W          = KEY_W + BLK_W,
  parameter int CNT_W           = 48,
  parameter int RESEED_INTERVAL = 2**20,
  parameter int UPD_TIMEOUT     = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [SEED_W-1:0] entropy_in,
  input  logic              entropy_valid,
  input  logic [SEED_W-1:0] pers_in,
  input  logic [SEED_W-1:0] addl_in,
  input  logic              gen_inc,
  input  logic              zeroize,
  output logic              upd_start,
  output logic [SEED_W-1:0] upd_data,
  output logic [KEY_W-1:0]  upd_key_o,
  output logic [BLK_W-1:0]  upd_v_o,
  input  logic              upd_done,
  input  logic [KEY_W-1:0]  upd_key,
  input  logic [BLK_W-1:0]  upd_v,
  output logic [KEY_W-1:0]  key_out,
  output logic [BLK_W-1:0]  v_out,
  output logic [CNT_W-1:0]  reseed_counter,
  output logic              instantiated,
  output logic              reseed_required,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int               TMO_W    = $clog2(UPD_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(UPD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] INTERVAL = CNT_W'(RESEED_INTERVAL);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {IDLE, UPD_WAIT} state_e;

  state_e            state_q, state_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              upd_start_q, upd_start_d;
  logic [SEED_W-1:0] upd_data_q, upd_data_d;
  logic [KEY_W-1:0]  upd_key_o_q, upd_key_o_d;
  logic [BLK_W-1:0]  upd_v_o_q, upd_v_o_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [BLK_W-1:0]  v_q, v_d;
  logic [CNT_W-1:0]  ctr_q, ctr_d;
  logic              inst_q, inst_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  always_comb begin
    // NOTE: every _d gets a default before any branch so no path leaves it unassigned (no latch).
    state_d     = state_q;
    tmo_d       = tmo_q;
    upd_start_d = 1'b0;
    upd_data_d  = upd_data_q;
    upd_key_o_d = upd_key_o_q;
    upd_v_o_d   = upd_v_o_q;
    key_d       = key_q;
    v_d         = v_q;
    ctr_d       = ctr_q;
    inst_d      = inst_q;
    done_d      = 1'b0;
    error_d     = 1'b0;

    if (zeroize) begin
      state_d     = IDLE;
      tmo_d       = '0;
      upd_data_d  = '0;
      upd_key_o_d = '0;
      upd_v_o_d   = '0;
      key_d       = '0;
      v_d         = '0;
      ctr_d       = '0;
      inst_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gen_inc && inst_q && (ctr_q != CNT_MAX)) ctr_d = ctr_q + CNT_W'(1);
          if (start) begin
            if (!entropy_valid || (mode && !inst_q)) begin
              error_d = 1'b1;
            end else begin
              upd_data_d  = entropy_in ^ (mode ? addl_in : pers_in);
              // Instantiate starts the update from an all-zero Key/V.
              upd_key_o_d = mode ? key_q : '0;
              upd_v_o_d   = mode ? v_q : '0;
              upd_start_d = 1'b1;
              tmo_d       = '0;
              state_d     = UPD_WAIT;
            end
          end
        end
        UPD_WAIT: begin
          tmo_d = tmo_q + TMO_W'(1);
          // A result arriving on the timeout edge still counts as success.
          if (upd_done) begin
            key_d   = upd_key;
            v_d     = upd_v;
            ctr_d   = CNT_W'(1);
            inst_d  = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (tmo_q == TMO_LAST) begin
            error_d = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      upd_start_q <= 1'b0;
      upd_data_q  <= '0;
      upd_key_o_q <= '0;
      upd_v_o_q   <= '0;
      key_q       <= '0;
      v_q         <= '0;
      ctr_q       <= '0;
      inst_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      upd_start_q <= upd_start_d;
      upd_data_q  <= upd_data_d;
      upd_key_o_q <= upd_key_o_d;
      upd_v_o_q   <= upd_v_o_d;
      key_q       <= key_d;
      v_q         <= v_d;
      ctr_q       <= ctr_d;
      inst_q      <= inst_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign upd_start       = upd_start_q;
  assign upd_data        = upd_data_q;
  assign upd_key_o       = upd_key_o_q;
  assign upd_v_o         = upd_v_o_q;
  assign key_out         = key_q;
  assign v_out           = v_q;
  assign reseed_counter  = ctr_q;
  assign instantiated    = inst_q;
  assign reseed_required = inst_q && (ctr_q > INTERVAL);
  assign busy            = (state_q == UPD_WAIT);
  assign done            = done_q;
  assign error           = error_q;

endmodule

// File: tb/tb_ctr_drbg_seed_ctrl.sv
// Scoreboard bench for ctr_drbg_seed_ctrl: stimulus queues expected engine requests and
// completions; a negedge monitor pops and compares whenever upd_start, done or error fire.
module tb_ctr_drbg_seed_ctrl;

  localparam int KEY_W  = 256;
  localparam int BLK_W  = 128;
  localparam int SEED_W = KEY_W + BLK_W;
  localparam int CNT_W  = 48;

  logic              clk = 1'b0;
  logic              rst;
  logic              start, mode, entropy_valid, gen_inc, zeroize;
  logic [SEED_W-1:0] entropy_in, pers_in, addl_in;
  logic              upd_start, upd_done;
  logic [SEED_W-1:0] upd_data;
  logic [KEY_W-1:0]  upd_key_o, upd_key, key_out;
  logic [BLK_W-1:0]  upd_v_o, upd_v, v_out;
  logic [CNT_W-1:0]  reseed_counter;
  logic              instantiated, reseed_required, busy, done, error;

  ctr_drbg_seed_ctrl #(
    .KEY_W(KEY_W), .BLK_W(BLK_W), .CNT_W(CNT_W),
    .RESEED_INTERVAL(3), .UPD_TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .entropy_in(entropy_in), .entropy_valid(entropy_valid),
    .pers_in(pers_in), .addl_in(addl_in), .gen_inc(gen_inc), .zeroize(zeroize),
    .upd_start(upd_start), .upd_data(upd_data), .upd_key_o(upd_key_o), .upd_v_o(upd_v_o),
    .upd_done(upd_done), .upd_key(upd_key), .upd_v(upd_v),
    .key_out(key_out), .v_out(v_out), .reseed_counter(reseed_counter),
    .instantiated(instantiated), .reseed_required(reseed_required),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {EV_REQ, EV_DONE, EV_ERR} ev_e;
  typedef struct {
    ev_e               kind;
    logic [SEED_W-1:0] data;
    logic [KEY_W-1:0]  key;
    logic [BLK_W-1:0]  v;
    logic [CNT_W-1:0]  ctr;
    logic              inst;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Bench-side view of the working state, updated by hand as each operation is queued.
  logic [KEY_W-1:0] m_key;
  logic [BLK_W-1:0] m_v;
  logic [CNT_W-1:0] m_ctr;
  logic             m_inst;

  task automatic check(input string name, input logic [SEED_W-1:0] act, input logic [SEED_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input ev_e k, input logic [SEED_W-1:0] d, input logic [KEY_W-1:0] key,
                      input logic [BLK_W-1:0] v, input logic [CNT_W-1:0] ctr, input logic inst);
    sb_q.push_back('{k, d, key, v, ctr, inst});
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic m, input logic [SEED_W-1:0] ent, input logic [SEED_W-1:0] other,
                       input logic ev);
    start = 1'b1; mode = m; entropy_in = ent; entropy_valid = ev;
    if (m) addl_in = other; else pers_in = other;
    tick();
    start = 1'b0;
  endtask

  // Engine answers so that upd_done is sampled n edges after the one that launched upd_start.
  task automatic engine(input int n, input logic [KEY_W-1:0] k, input logic [BLK_W-1:0] v);
    repeat (n - 1) tick();
    upd_done = 1'b1; upd_key = k; upd_v = v;
    tick();
    upd_done = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
    check(name, sb_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && (upd_start || done || error)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", {done, error, upd_start}, 0);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.kind == EV_REQ) begin
          check("req_start", {done, error, upd_start}, 3'b001);
          check("req_data", upd_data, mon_e.data);
          check("req_key", upd_key_o, mon_e.key);
          check("req_v", upd_v_o, mon_e.v);
        end else begin
          check("resp_flags", {done, error, upd_start}, {mon_e.kind == EV_DONE, mon_e.kind == EV_ERR, 1'b0});
          check("resp_key", key_out, mon_e.key);
          check("resp_v", v_out, mon_e.v);
          check("resp_ctr", reseed_counter, mon_e.ctr);
          check("resp_inst", instantiated, mon_e.inst);
          check("resp_busy", busy, 0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; mode = 1'b0; entropy_valid = 1'b0; gen_inc = 1'b0; zeroize = 1'b0;
    entropy_in = '0; pers_in = '0; addl_in = '0; upd_done = 1'b0; upd_key = '0; upd_v = '0;
    m_key = '0; m_v = '0; m_ctr = '0; m_inst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_key", key_out, 0);
    check("rst_v", v_out, 0);
    check("rst_ctr", reseed_counter, 0);
    check("rst_flags", {instantiated, reseed_required, busy, done, error, upd_start}, 0);
    check("rst_upd", {upd_key_o, upd_v_o}, 0);
    check("rst_data", upd_data, 0);
    rst = 1'b0;
    tick();

    // Reseed before instantiate, then an Instantiate with unhealthy entropy: both rejected.
    push(EV_ERR, '0, m_key, m_v, m_ctr, m_inst);
    issue(1'b1, {12{32'h1111_2222}}, {12{32'h3333_4444}}, 1'b1);
    check("rej_busy", busy, 0);
    tick();
    check("rej_busy_after", busy, 0);
    push(EV_ERR, '0, m_key, m_v, m_ctr, m_inst);
    issue(1'b0, '1, '0, 1'b0);
    check("rej_ev_busy", busy, 0);
    wait_drain("rej_drain");

    // Instantiate: entropy all-ones, pers zero, engine replies three cycles later.
    push(EV_REQ, '1, '0, '0, '0, 1'b0);
    m_key = {32{8'hAA}}; m_v = {16{8'h55}}; m_ctr = 1; m_inst = 1'b1;
    push(EV_DONE, '0, m_key, m_v, m_ctr, m_inst);
    issue(1'b0, '1, '0, 1'b1);
    check("inst_busy", busy, 1);
    engine(3, {32{8'hAA}}, {16{8'h55}});
    check("inst_done", done, 1);
    tick();
    check("inst_done_once", done, 0);
    wait_drain("inst_drain");

    // Generate counting across the interval boundary (interval 3).
    gen_inc = 1'b1; tick(); tick(); gen_inc = 1'b0;
    check("gen_ctr3", reseed_counter, 3);
    check("gen_rr_at_interval", reseed_required, 0);
    gen_inc = 1'b1; tick(); tick(); gen_inc = 1'b0;
    check("gen_ctr5", reseed_counter, 5);
    check("gen_rr_over", reseed_required, 1);

    // Reseed: gen_inc and start while waiting are both ignored.
    push(EV_REQ, {12{32'hFFFF_0000}}, {32{8'hAA}}, {16{8'h55}}, '0, 1'b0);
    m_key = {8{32'hC0DE_0001}}; m_v = {4{32'hBEEF_0001}}; m_ctr = 1;
    push(EV_DONE, '0, m_key, m_v, m_ctr, m_inst);
    issue(1'b1, {12{32'hF0F0_1234}}, {12{32'h0F0F_1234}}, 1'b1);
    gen_inc = 1'b1; start = 1'b1;
    tick();
    gen_inc = 1'b0; start = 1'b0;
    check("wait_ctr_hold", reseed_counter, 5);
    engine(1, {8{32'hC0DE_0001}}, {4{32'hBEEF_0001}});
    check("reseed_rr_clear", reseed_required, 0);

    // Back-to-back reseed accepted on the edge after done, engine at minimum latency.
    push(EV_REQ, {12{32'h0000_FFFF}}, m_key, m_v, '0, 1'b0);
    m_key = {8{32'hC0DE_0002}}; m_v = {4{32'hBEEF_0002}};
    push(EV_DONE, '0, m_key, m_v, m_ctr, m_inst);
    issue(1'b1, {12{32'h5555_AAAA}}, {12{32'h5555_5555}}, 1'b1);
    check("b2b_busy", busy, 1);
    engine(1, {8{32'hC0DE_0002}}, {4{32'hBEEF_0002}});
    check("min_latency_done", done, 1);
    wait_drain("reseed_drain");

    // Timeout with no reply: error eight cycles after upd_start, state held.
    push(EV_REQ, {12{32'h1234_5678}}, m_key, m_v, '0, 1'b0);
    push(EV_ERR, '0, m_key, m_v, m_ctr, m_inst);
    issue(1'b1, {12{32'h1234_5678}}, '0, 1'b1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (error) break;
    end
    check("tmo_cycles", n, 8);
    tick();

    // Reply on the timeout edge: done wins.
    push(EV_REQ, {12{32'h8765_4321}}, m_key, m_v, '0, 1'b0);
    m_key = {8{32'hC0DE_0003}}; m_v = {4{32'hBEEF_0003}};
    push(EV_DONE, '0, m_key, m_v, m_ctr, m_inst);
    issue(1'b1, {12{32'h8765_4321}}, '0, 1'b1);
    engine(8, {8{32'hC0DE_0003}}, {4{32'hBEEF_0003}});
    check("tmo_edge_flags", {done, error}, 2'b10);
    wait_drain("tmo_drain");

    // Zeroize mid-wait; a late reply must be ignored.
    push(EV_REQ, {12{32'hA5A5_A5A5}}, m_key, m_v, '0, 1'b0);
    issue(1'b1, {12{32'hA5A5_A5A5}}, '0, 1'b1);
    tick();
    zeroize = 1'b1; tick(); zeroize = 1'b0;
    m_key = '0; m_v = '0; m_ctr = '0; m_inst = 1'b0;
    check("zero_key", key_out, 0);
    check("zero_v", v_out, 0);
    check("zero_ctr", reseed_counter, 0);
    check("zero_flags", {instantiated, busy, done, error, upd_start, reseed_required}, 0);
    check("zero_upd", {upd_key_o, upd_v_o}, 0);
    check("zero_data", upd_data, 0);
    tick();
    upd_done = 1'b1; upd_key = '1; upd_v = '1;
    tick();
    upd_done = 1'b0;
    tick();
    check("late_done_key", key_out, 0);
    check("late_done_inst", instantiated, 0);

    // Asynchronous reset in the middle of a reseed.
    push(EV_REQ, {12{32'h0F0F_0F0F}}, '0, '0, '0, 1'b0);
    m_key = {8{32'hC0DE_0004}}; m_v = {4{32'hBEEF_0004}}; m_ctr = 1; m_inst = 1'b1;
    push(EV_DONE, '0, m_key, m_v, m_ctr, m_inst);
    issue(1'b0, {12{32'hFFFF_FFFF}}, {12{32'hF0F0_F0F0}}, 1'b1);
    engine(1, {8{32'hC0DE_0004}}, {4{32'hBEEF_0004}});
    wait_drain("pre_rst_drain");
    push(EV_REQ, {12{32'h0000_1111}}, m_key, m_v, '0, 1'b0);
    issue(1'b1, {12{32'h0000_1111}}, '0, 1'b1);
    tick();
    #1 rst = 1'b1;
    #1;
    check("arst_key", key_out, 0);
    check("arst_v", v_out, 0);
    check("arst_ctr", reseed_counter, 0);
    check("arst_flags", {instantiated, busy, done, error, upd_start}, 0);
    check("arst_upd", {upd_key_o, upd_v_o}, 0);
    tick();
    rst = 1'b0;
    tick();
    wait_drain("final_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ctr_drbg_seed_ctrl.md
# ctr_drbg_seed_ctrl

Parametrised CTR_DRBG (no derivation function) seed controller. It owns the working state (Key, V, reseed_counter) and runs both Instantiate and Reseed. Each operation XORs the entropy input with the personalization string or additional input, then drives an external update engine over a start/done handshake. It also tracks generate requests against the reseed interval and supports zeroization. It sits between the DRBG top-level command decoder and the shared update/AES engine.

## Interface
Parameters:
- KEY_W, 256: key width; legal values 128 and 256.
- BLK_W, 128: block/V width (fixed AES block).
- SEED_W, KEY_W+BLK_W: seed material width (derived; do not override).
- CNT_W, 48: reseed counter width.
- RESEED_INTERVAL, 2**20: maximum generates allowed before reseed_required asserts.
- UPD_TIMEOUT, 64: maximum cycles to wait for upd_done.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset; asynchronous, active-high.
- start, in, 1: command strobe; sampled only in IDLE.
- mode, in, 1: 0 = Instantiate, 1 = Reseed.
- entropy_in, in, SEED_W: entropy input.
- entropy_valid, in, 1: entropy source health OK.
- pers_in, in, SEED_W: personalization string (Instantiate).
- addl_in, in, SEED_W: additional input (Reseed).
- gen_inc, in, 1: one-cycle pulse per completed generate.
- zeroize, in, 1: clear all state; highest priority.
- upd_start, out, 1: one-cycle request to the update engine.
- upd_data, out, SEED_W: provided_data to the engine.
- upd_key_o, out, KEY_W: current Key sent to the engine.
- upd_v_o, out, BLK_W: current V sent to the engine.
- upd_done, in, 1: engine result valid (one-cycle pulse).
- upd_key, in, KEY_W: new Key from the engine.
- upd_v, in, BLK_W: new V from the engine.
- key_out, out, KEY_W: working Key.
- v_out, out, BLK_W: working V.
- reseed_counter, out, CNT_W: working counter.
- instantiated, out, 1: working state is valid.
- reseed_required, out, 1: instantiated && reseed_counter > RESEED_INTERVAL (combinational).
- busy, out, 1: high outside IDLE.
- done, out, 1: one-cycle success pulse.
- error, out, 1: one-cycle failure pulse.

## Operation
- States: IDLE, UPD_WAIT. Every output is 0 at reset; state resets to IDLE.
- IDLE with start=1, checked in this order:
  - entropy_valid=0 -> error, stay IDLE.
  - mode=1 with instantiated=0 -> error, stay IDLE.
  - Otherwise, latch upd_data = entropy_in ^ (mode ? addl_in : pers_in).
  - Latch upd_key_o/upd_v_o = mode ? key_out/v_out : 0.
  - Assert upd_start, go to UPD_WAIT, clear the timeout counter.
- UPD_WAIT:
  - upd_start drops after one cycle.
  - The timeout counter increments every cycle.
  - upd_done=1 -> key_out<=upd_key, v_out<=upd_v, reseed_counter<=1, instantiated<=1, done<=1, go to IDLE.
  - Timeout counter reaching UPD_TIMEOUT without upd_done -> error<=1, go to IDLE. Key, V, counter and instantiated are unchanged.
  - upd_done on the same edge as the timeout -> done wins.
- gen_inc in IDLE with instantiated=1 increments reseed_counter, saturating at all-ones. gen_inc is ignored otherwise.
- zeroize, any state: on the next edge, clear key_out, v_out, reseed_counter, instantiated, upd_* outputs and the timeout counter; go to IDLE; no done/error. A late upd_done after zeroize is ignored.
- start in UPD_WAIT is ignored; it is neither queued nor flagged.

## Timing
- Edge E0 samples start (accepted). upd_start is high for exactly cycle E0–E1; busy is high from E0.
- upd_done sampled at edge En -> key_out/v_out/reseed_counter update at En; done is high for cycle En–En+1; busy falls at En.
- Minimum latency start->done is 2 edges, when the engine answers one cycle after upd_start.
- A rejected start gives error high for the cycle after E0; busy never rises.
- A new start is accepted on the edge after done/error.
- reseed_required follows reseed_counter with no added latency.

## Test plan
- Instantiate: entropy=all-ones, pers=0, engine returns key=0xAA.., v=0x55.. three cycles after upd_start. Required: upd_data=all-ones, upd_key_o=0, done one cycle, reseed_counter=1, instantiated=1.
- Reseed before instantiate: mode=1 from reset. Required: error pulse, busy stays 0, upd_start stays 0.
- Reseed after instantiate: upd_key_o equals the prior key_out; upd_data=entropy^addl; counter resets to 1 from 5.
- Interval: RESEED_INTERVAL=3, four gen_inc pulses. Required: counter=5, reseed_required=1; a reseed returns reseed_required to 0.
- Timeout: UPD_TIMEOUT=8, no upd_done. Required: error exactly 8 cycles after upd_start; key/v unchanged. Repeat with upd_done on the timeout edge -> done, no error.
- Zeroize mid-UPD_WAIT, then upd_done two cycles later. Required: all state 0, no done, instantiated=0; also check rst asserted mid-operation clears all outputs immediately.
